// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter sequencer: FSM states,
// letter codes, the letter-to-Morse table and the unit lengths of each phase.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ON,
        GAP,
        LGAP,
        WGAP
    } state_t;

    typedef logic [2:0] letter_t;

    typedef struct packed {
        logic [2:0] len;
        logic [3:0] pattern;
    } morse_code_t;

    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] EGAP_UNITS       = 3'd1;
    localparam logic [2:0] LGAP_UNITS       = 3'd3;
    localparam logic [2:0] WGAP_EXTRA_UNITS = 3'd4;

    // Patterns are left-aligned so the element being played is always bit 3 (1 = dash).
    function automatic morse_code_t morse_lookup(input letter_t code);
        morse_code_t mc;
        mc = '0;
        case (code)
            3'd0: mc = '{len: 3'd2, pattern: 4'b0100};
            3'd1: mc = '{len: 3'd4, pattern: 4'b1000};
            3'd2: mc = '{len: 3'd4, pattern: 4'b1010};
            3'd3: mc = '{len: 3'd3, pattern: 4'b1000};
            3'd4: mc = '{len: 3'd1, pattern: 4'b0000};
            3'd5: mc = '{len: 3'd4, pattern: 4'b0010};
            3'd6: mc = '{len: 3'd3, pattern: 4'b1100};
            3'd7: mc = '{len: 3'd4, pattern: 4'b0000};
        endcase
        return mc;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Morse unit divider: one-cycle tick every TICK_DIV clocks, restartable so a
// freshly popped letter always gets a full first unit.
module morse_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Letter FIFO plus Morse playback FSM driving a single LED on CLOCK_50.
// Define MORSE_WORD_GAP_EN to extend the gap after the last queued letter to a 7-unit word gap.
module morse_sequencer #(
    parameter int TICK_DIV   = 12_500_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       letter_valid,
    input  logic [2:0] letter,
    output logic       letter_ready,
    output logic       led,
    output logic [2:0] cur_letter,
    output logic       busy,
    output logic       done
);
    import morse_pkg::*;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    state_t           state_q, state_d;
    logic             led_q, led_d;
    logic [2:0]       unit_q, unit_d;
    logic [3:0]       pattern_q, pattern_d;
    logic [2:0]       left_q, left_d;
    letter_t          cur_letter_q, cur_letter_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    letter_t          fifo_mem_q [FIFO_DEPTH];

    logic        tick;
    logic        push;
    logic        pop;
    logic        done_c;
    logic        fifo_empty;
    logic [2:0]  unit_next;
    logic [2:0]  elem_units;
    morse_code_t head_code;

    morse_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .clear   (pop),
        .tick    (tick)
    );

    assign fifo_empty   = (count_q == '0);
    assign letter_ready = (count_q != FULL_COUNT);
    assign push         = letter_valid && letter_ready;
    assign head_code    = morse_lookup(fifo_mem_q[rd_ptr_q]);
    assign unit_next    = unit_q + 3'd1;
    assign elem_units   = pattern_q[3] ? DASH_UNITS : DOT_UNITS;

    assign led        = led_q;
    assign cur_letter = cur_letter_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign done       = done_c && !reset;

    always_comb begin
        state_d      = state_q;
        led_d        = led_q;
        unit_d       = unit_q;
        pattern_d    = pattern_q;
        left_d       = left_q;
        cur_letter_d = cur_letter_q;
        pop          = 1'b0;
        done_c       = 1'b0;

        case (state_q)
            IDLE: pop = !fifo_empty;
            ON: begin
                if (tick) begin
                    if (unit_next == elem_units) begin
                        unit_d  = '0;
                        led_d   = 1'b0;
                        state_d = (left_q != 3'd0) ? GAP : LGAP;
                    end else begin
                        unit_d = unit_next;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (unit_next == EGAP_UNITS) begin
                        unit_d    = '0;
                        pattern_d = {pattern_q[2:0], 1'b0};
                        left_d    = left_q - 3'd1;
                        led_d     = 1'b1;
                        state_d   = ON;
                    end else begin
                        unit_d = unit_next;
                    end
                end
            end
            LGAP: begin
                if (tick) begin
                    if (unit_next == LGAP_UNITS) begin
                        unit_d = '0;
                        if (!fifo_empty) begin
                            done_c = 1'b1;
                            pop    = 1'b1;
                        end else begin
`ifdef MORSE_WORD_GAP_EN
                            state_d = WGAP;
`else
                            done_c  = 1'b1;
                            state_d = IDLE;
`endif
                        end
                    end else begin
                        unit_d = unit_next;
                    end
                end
            end
`ifdef MORSE_WORD_GAP_EN
            // Pushes landing here stay queued; IDLE picks them up after the word gap.
            WGAP: begin
                if (tick) begin
                    if (unit_next == WGAP_EXTRA_UNITS) begin
                        unit_d  = '0;
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        unit_d = unit_next;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (pop) begin
            pattern_d    = head_code.pattern;
            left_d       = head_code.len - 3'd1;
            unit_d       = '0;
            led_d        = 1'b1;
            cur_letter_d = fifo_mem_q[rd_ptr_q];
            state_d      = ON;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= IDLE;
            led_q        <= 1'b0;
            unit_q       <= '0;
            pattern_q    <= '0;
            left_q       <= '0;
            cur_letter_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            led_q        <= led_d;
            unit_q       <= unit_d;
            pattern_q    <= pattern_d;
            left_q       <= left_d;
            cur_letter_q <= cur_letter_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= letter;
        end
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer: a waveform-level model expands each
// queued letter into its expected per-cycle LED stream and is compared every cycle.
module tb_morse_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef MORSE_WORD_GAP_EN
    localparam int WG = 16;
`else
    localparam int WG = 0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       letterValid;
    logic [2:0] letterCode;
    logic       letterReady;
    logic       led;
    logic [2:0] curLetter;
    logic       busy;
    logic       done;

    int checks   = 0;
    int errors   = 0;
    bit checkEn  = 1'b0;
    int doneSeen = 0;

    // Model: queued letters, remaining LED stream of the current phase,
    // kind 0 = idle, 1 = letter playing, 2 = trailing word gap.
    logic [2:0] mq[$];
    bit         wave[$];
    int         kind = 0;
    logic [2:0] mCur = 3'd0;
    bit         mPush;
    bit         mStart;
    bit         mLast;
    logic       expLed;
    logic       expDone;

    morse_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .letter_valid(letterValid),
        .letter      (letterCode),
        .letter_ready(letterReady),
        .led         (led),
        .cur_letter  (curLetter),
        .busy        (busy),
        .done        (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic string morseString(input logic [2:0] l);
        case (l)
            3'd0:    return ".-";
            3'd1:    return "-...";
            3'd2:    return "-.-.";
            3'd3:    return "-..";
            3'd4:    return ".";
            3'd5:    return "..-.";
            3'd6:    return "--.";
            default: return "....";
        endcase
    endfunction

    function automatic void loadWave(input logic [2:0] l);
        string s;
        s = morseString(l);
        wave.delete();
        for (int i = 0; i < s.len(); i++) begin
            int onUnits;
            int offUnits;
            onUnits  = (s[i] == "-") ? 3 : 1;
            offUnits = (i == s.len() - 1) ? 3 : 1;
            repeat (onUnits * TICK_DIV) wave.push_back(1'b1);
            repeat (offUnits * TICK_DIV) wave.push_back(1'b0);
        end
    endfunction

    function automatic int countOnes();
        int n = 0;
        foreach (wave[i]) n += int'(wave[i]);
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model advances on every rising edge using the inputs held across it.
    initial begin
        forever begin
            @(posedge CLOCK_50);
            mPush = letterValid && (mq.size() < FIFO_DEPTH);
            if (reset) begin
                mq.delete();
                wave.delete();
                kind = 0;
                mCur = 3'd0;
            end else begin
                mStart = 1'b0;
                if (kind == 0) begin
                    mStart = (mq.size() != 0);
                end else begin
                    mLast = (wave.size() == 1);
                    void'(wave.pop_front());
                    if (mLast) begin
                        if (kind == 1 && mq.size() != 0) begin
                            mStart = 1'b1;
                        end else if (kind == 1 && WG != 0) begin
                            kind = 2;
                            repeat (WG) wave.push_back(1'b0);
                        end else begin
                            kind = 0;
                        end
                    end
                end
                if (mStart) begin
                    mCur = mq.pop_front();
                    loadWave(mCur);
                    kind = 1;
                end
                if (mPush) mq.push_back(letterCode);
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (done === 1'b1) doneSeen++;
            if (checkEn) begin
                expLed  = (kind != 0) ? wave[0] : 1'b0;
                expDone = 1'b0;
                if (kind == 1 && wave.size() == 1) expDone = (WG == 0) || (mq.size() != 0);
                if (kind == 2 && wave.size() == 1) expDone = 1'b1;
                if (reset) expDone = 1'b0;
                checkOutput("led", led, expLed);
                checkOutput("done", done, expDone);
                checkOutput("busy", busy, (kind != 0) || (mq.size() != 0));
                checkOutput("letter_ready", letterReady, mq.size() < FIFO_DEPTH);
                checkOutput("cur_letter", curLetter, mCur);
            end
        end
    end

    task automatic cycle();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] l, input logic r);
        letterValid = v;
        letterCode  = l;
        reset       = r;
        cycle();
    endtask

    task automatic pushLetter(input logic [2:0] l);
        bit accepted = 1'b0;
        for (int c = 0; c < 400 && !accepted; c++) begin
            accepted = (mq.size() < FIFO_DEPTH);
            applyStimulus(1'b1, l, 1'b0);
        end
        letterValid = 1'b0;
        if (!accepted) checkOutput("push_timeout", 0, 1);
    endtask

    task automatic waitIdle(input int budget);
        int c = 0;
        while ((kind != 0 || mq.size() != 0) && c < budget) begin
            cycle();
            c++;
        end
        checkOutput("idle_reached", (kind == 0 && mq.size() == 0), 1);
    endtask

    // Counts cycles from the first LED-high cycle through the done cycle, inclusive.
    task automatic measureLetter(output int riseToDone, output int highs);
        bit rose = 1'b0;
        int n = 0;
        riseToDone = -1;
        highs = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLOCK_50);
            if (led === 1'b1) rose = 1'b1;
            if (rose) begin
                n++;
                if (led === 1'b1) highs++;
                if (done === 1'b1) begin
                    riseToDone = n;
                    break;
                end
            end
        end
        cycle();
    endtask

    initial begin
        int r2d;
        int highs;
        int d0;
        int acc;
        logic v;

        letterValid = 1'b0;
        letterCode  = 3'd0;
        reset       = 1'b1;

        loadWave(3'd0);
        checkOutput("model_A_len", wave.size(), 32);
        checkOutput("model_A_high", countOnes(), 16);
        loadWave(3'd5);
        checkOutput("model_F_len", wave.size(), 48);
        loadWave(3'd7);
        checkOutput("model_H_len", wave.size(), 40);
        wave.delete();

        applyStimulus(1'b0, 3'd0, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b1);
        reset   = 1'b0;
        checkEn = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("reset_led", led, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ready", letterReady, 1);
        checkOutput("reset_cur", curLetter, 0);
        checkOutput("reset_done", done, 0);

        pushLetter(3'd0);
        measureLetter(r2d, highs);
        checkOutput("A_rise_to_done", r2d, 32 + WG);
        checkOutput("A_high_cycles", highs, 16);
        @(negedge CLOCK_50);
        checkOutput("A_busy_after_done", busy, 0);
        checkOutput("A_cur", curLetter, 0);
        waitIdle(100);

        pushLetter(3'd4);
        measureLetter(r2d, highs);
        checkOutput("E_rise_to_done", r2d, 16 + WG);
        checkOutput("E_high_cycles", highs, 4);
        waitIdle(100);

        d0 = doneSeen;
        applyStimulus(1'b1, 3'd1, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0);
        applyStimulus(1'b1, 3'd7, 1'b0);
        applyStimulus(1'b1, 3'd6, 1'b0);
        pushLetter(3'd0);
        @(negedge CLOCK_50);
        checkOutput("full_ready_low", letterReady, 0);
        pushLetter(3'd3);
        @(negedge CLOCK_50);
        checkOutput("push_pop_ready_low", letterReady, 0);
        waitIdle(2000);
        checkOutput("b2b_done_count", doneSeen - d0, 6);

        pushLetter(3'd3);
        repeat (6) cycle();
        d0 = doneSeen;
        applyStimulus(1'b1, 3'd5, 1'b1);
        reset       = 1'b0;
        letterValid = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("rst_led", led, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", letterReady, 1);
        checkOutput("rst_no_done", doneSeen - d0, 0);
        pushLetter(3'd5);
        measureLetter(r2d, highs);
        checkOutput("F_rise_to_done", r2d, 48 + WG);
        checkOutput("F_high_cycles", highs, 24);
        checkOutput("F_cur", curLetter, 5);
        waitIdle(100);

        d0  = doneSeen;
        acc = 0;
        for (int i = 0; i < 500; i++) begin
            v = ($urandom_range(0, 3) == 0);
            if (v && mq.size() < FIFO_DEPTH) acc++;
            applyStimulus(v, 3'($urandom_range(0, 7)), 1'b0);
        end
        letterValid = 1'b0;
        waitIdle(5000);
        checkOutput("random_done_count", doneSeen - d0, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
